vga_framebuffer: RTL and testbench
==================================

Name: vga_framebuffer

Overview:
Double-buffered low-resolution frame store that sits directly upstream of the VGA timing controller. It converts the controller's current pixel coordinates (cur_X, cur_Y) into 1-bit red/green/blue pixel values. Each stored pixel is shown as a 4x4 block. Game logic draws into the back buffer through a valid/ready write port. It can also bulk-clear the back buffer, and it requests a buffer swap that takes effect only at vertical sync so the image never tears.

Parameters:
FB_W, 160, framebuffer width in stored pixels (640 >> SCALE_SHIFT)
FB_H, 120, framebuffer height in stored pixels (480 >> SCALE_SHIFT)
SCALE_SHIFT, 2, log2 of the display pixels per stored pixel, applied on each axis
ADDR_W, 15, RAM address width; must satisfy 2^ADDR_W >= FB_W*FB_H

Ports:
clk  in  1  system/pixel clock, the same clock as the VGA controller
rst  in  1  reset, synchronous, active-high
cur_X  in  10  current display column from the VGA controller (0..639)
cur_Y  in  10  current display row from the VGA controller (0..479)
vga_vs  in  1  vertical sync from the VGA controller, active-low pulse
red  out  1  pixel red to the VGA controller
green  out  1  pixel green to the VGA controller
blue  out  1  pixel blue to the VGA controller
wr_valid  in  1  host write request
wr_ready  out  1  write port can accept a write
wr_x  in  8  stored-pixel column of the write
wr_y  in  7  stored-pixel row of the write
wr_rgb  in  3  write colour, bit order {r,g,b}
clr_req  in  1  one-cycle pulse: fill the back buffer with clr_rgb
clr_rgb  in  3  fill colour, sampled in the cycle clr_req is accepted
swap_req  in  1  one-cycle pulse: exchange the front and back buffers at the next vsync
busy  out  1  high in CLEAR and SWAP_WAIT
clr_done  out  1  one-cycle pulse when the clear completes
swap_done  out  1  one-cycle pulse when the swap takes effect
front_sel  out  1  index of the buffer currently displayed

Behaviour:
- Storage: two RAMs, each FB_W*FB_H x 3 bits. RAM contents are not reset. front_sel selects the displayed RAM; writes and clears always target RAM !front_sel.
- Read pipeline, fixed latency of 2 cycles:
  - Stage 1 registers addr = (cur_Y>>SCALE_SHIFT)*FB_W + (cur_X>>SCALE_SHIFT), computed as (y<<7)+(y<<5)+x for the defaults, ADDR_W bits with no overflow.
  - Stage 2 registers the front-RAM data onto {red,green,blue}.
  - The horizontal image shift of 2 pixels is accepted and is not compensated.
- Vsync edge: vs_d is registered from vga_vs and resets to 1. vs_fall = vs_d & ~vga_vs.
- FSM states: IDLE, CLEAR, SWAP_WAIT. Reset state is IDLE.
- IDLE:
  - wr_ready=1.
  - A write is accepted when wr_valid & wr_ready. It is written to the back RAM on that edge.
  - If wr_x>=FB_W or wr_y>=FB_H, the write is accepted and dropped, with no RAM write.
  - clr_req -> CLEAR: latch clr_rgb and set cnt=0.
  - Otherwise swap_req -> SWAP_WAIT.
  - If clr_req and swap_req arrive in the same cycle, clr_req wins and swap_req is ignored.
  - A write accepted in the same cycle as a request is still performed.
- CLEAR:
  - wr_ready=0.
  - Each cycle writes the latched colour to back[cnt] and increments cnt.
  - After writing cnt=FB_W*FB_H-1 (19199): clr_done=1 for one cycle and the FSM returns to IDLE. Total 19200 cycles in CLEAR.
  - clr_req and swap_req pulses received in CLEAR are ignored.
- SWAP_WAIT:
  - wr_ready=0.
  - On vs_fall: toggle front_sel, swap_done=1 for one cycle, return to IDLE.
  - Requests received in SWAP_WAIT are ignored.
  - If vs_fall coincides with entry into SWAP_WAIT, it is not used; the FSM waits for the next falling edge.
- busy = (state != IDLE), driven combinationally from the state.
- Reset values, and rst asserted mid-operation:
  - Outputs: red=green=blue=0, wr_ready=0 while rst is high (1 in the first cycle after release), busy=0, clr_done=0, swap_done=0, front_sel=0.
  - Internal: cnt=0, state=IDLE, vs_d=1, pipeline registers=0.
  - rst asserted mid-CLEAR or mid-SWAP_WAIT aborts the operation immediately. A partially cleared buffer stays partially cleared, and no done pulse is generated.

Test Plan:
- Reset, then write (x=5,y=3,rgb=3'b101), then swap_req and wait for vs_fall: swap_done pulses and front_sel=1. With cur_X=20..23, cur_Y=12..15, {red,green,blue}=101 exactly 2 cycles after each coordinate is applied.
- Write (x=160,y=0) and (x=0,y=120): wr_ready stays 1 and both writes are accepted. After a swap, pixels at (0,0) and (159,119) are unchanged.
- clr_req with clr_rgb=3'b010: busy=1 for exactly 19200 cycles, wr_ready=0 throughout, one clr_done pulse. After a swap, reads at (0,0) and (639,479) return 010.
- clr_req and swap_req in the same cycle as a wr_valid to (1,1): CLEAR is entered, the swap is never performed (front_sel is unchanged after the next two vsyncs), and pixel (1,1) is overwritten by the clear.
- swap_req while vga_vs=1: front_sel holds until the first 1->0 transition of vga_vs, then toggles with a single swap_done pulse. A second swap_req sent during SWAP_WAIT is ignored.
- Assert rst for 1 cycle at cnt≈5000 of a CLEAR: the next cycle shows state IDLE, busy=0, no clr_done, front_sel=0, and outputs 0.

Source files
------------

// File: rtl/vga_framebuffer_if.sv
// Host-side port bundle for vga_framebuffer.
// Contents:
//   - Pixel write handshake: wr_valid / wr_ready plus wr_x, wr_y and wr_rgb ({r,g,b}).
//   - Back-buffer clear: clr_req, clr_rgb, clr_done.
//   - Buffer swap at vsync: swap_req, swap_done.
//   - Status: busy, front_sel.
// Modports:
//   - master: the game/host logic.
//   - slave: the framebuffer.
interface vga_framebuffer_if;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] wr_x;
   logic [6:0] wr_y;
   logic [2:0] wr_rgb;
   logic       clr_req;
   logic [2:0] clr_rgb;
   logic       swap_req;
   logic       busy;
   logic       clr_done;
   logic       swap_done;
   logic       front_sel;

   modport master (
      output wr_valid, wr_x, wr_y, wr_rgb, clr_req, clr_rgb, swap_req,
      input  wr_ready, busy, clr_done, swap_done, front_sel
   );

   modport slave (
      input  wr_valid, wr_x, wr_y, wr_rgb, clr_req, clr_rgb, swap_req,
      output wr_ready, busy, clr_done, swap_done, front_sel
   );
endinterface

// File: rtl/vga_framebuffer.sv
// Double-buffered low-resolution frame store that feeds the VGA timing controller.
// Each stored pixel is shown as a (1<<SCALE_SHIFT)-square block of display pixels.
// The host draws into the back buffer, can bulk-clear it, and requests a front/back
// swap; the swap takes effect on the next falling edge of vga_vs so the image never tears.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cur_X, cur_Y      current display coordinate from the VGA controller
//   vga_vs            vertical sync, active-low pulse
//   red, green, blue  pixel colour, 2 cycles after the coordinate is applied
//   host              write/clear/swap port (vga_framebuffer_if.slave)
module vga_framebuffer #(
   parameter int unsigned FB_W        = 160,
   parameter int unsigned FB_H        = 120,
   parameter int unsigned SCALE_SHIFT = 2,
   parameter int unsigned ADDR_W      = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [9:0]        cur_X,
   input  logic [9:0]        cur_Y,
   input  logic              vga_vs,
   output logic              red,
   output logic              green,
   output logic              blue,
   vga_framebuffer_if.slave  host
);
   localparam int unsigned       FB_PIX = FB_W * FB_H;
   localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(FB_W);
   localparam logic [ADDR_W-1:0] H_A    = ADDR_W'(FB_H);
   localparam logic [ADDR_W-1:0] PIX_A  = ADDR_W'(FB_PIX);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(FB_PIX - 1);

   typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_addr;
   logic [2:0]        clr_col;
   logic [2:0]        wr_data;
   logic              wr_en;
   logic              wr_fire;
   logic              wr_in_range;
   logic              vs_d;
   logic              vs_fall;
   logic              front_sel;

   logic [2:0] ram0 [FB_PIX];
   logic [2:0] ram1 [FB_PIX];

   assign vs_fall        = vs_d & ~vga_vs;
   assign host.busy      = (state != IDLE);
   assign host.wr_ready  = (state == IDLE) & ~rst;
   assign host.front_sel = front_sel;

   assign wr_fire     = host.wr_valid & host.wr_ready;
   assign wr_in_range = (ADDR_W'(host.wr_x) < W_A) && (ADDR_W'(host.wr_y) < H_A);

   // Single RAM write port shared by host writes (IDLE only) and the clear sweep.
   // Out-of-range host writes are handshaked but never reach the RAM.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      if (state == CLEAR && !rst) begin
         wr_en   = 1'b1;
         wr_addr = cnt;
         wr_data = clr_col;
      end else if (wr_fire && wr_in_range) begin
         wr_en   = 1'b1;
         wr_addr = ADDR_W'(host.wr_y) * W_A + ADDR_W'(host.wr_x);
         wr_data = host.wr_rgb;
      end
   end

   // The back buffer is always the one not being displayed.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (front_sel)
            ram0[wr_addr] <= wr_data;
         else
            ram1[wr_addr] <= wr_data;
      end
   end

   // Two-stage read: register the linear address, then the front-RAM data.
   // Addresses past the stored image (blanking rows) read as black.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr            <= '0;
         {red, green, blue} <= '0;
      end else begin
         rd_addr <= ADDR_W'(cur_Y >> SCALE_SHIFT) * W_A + ADDR_W'(cur_X >> SCALE_SHIFT);
         if (rd_addr < PIX_A)
            {red, green, blue} <= front_sel ? ram1[rd_addr] : ram0[rd_addr];
         else
            {red, green, blue} <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         clr_col        <= '0;
         vs_d           <= 1'b1;
         front_sel      <= 1'b0;
         host.clr_done  <= 1'b0;
         host.swap_done <= 1'b0;
      end else begin
         vs_d           <= vga_vs;
         host.clr_done  <= 1'b0;
         host.swap_done <= 1'b0;
         case (state)
            IDLE: begin
               if (host.clr_req) begin
                  state   <= CLEAR;
                  clr_col <= host.clr_rgb;
                  cnt     <= '0;
               end else if (host.swap_req) begin
                  state <= SWAP_WAIT;
               end
            end
            CLEAR: begin
               cnt <= cnt + ADDR_W'(1);
               if (cnt == LAST_A) begin
                  host.clr_done <= 1'b1;
                  state         <= IDLE;
               end
            end
            SWAP_WAIT: begin
               // A vsync edge in the entry cycle is seen while still in IDLE, so it is skipped.
               if (vs_fall) begin
                  front_sel      <= ~front_sel;
                  host.swap_done <= 1'b1;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vga_framebuffer.sv
// Self-checking bench for vga_framebuffer: a pixel-array model of both buffers
// is checked against the DUT every cycle, and directed scenarios pin known values.
`timescale 1ns/1ps
module tb_vga_framebuffer;
   logic       clk;
   logic       rst;
   logic [9:0] cur_X;
   logic [9:0] cur_Y;
   logic       vga_vs;
   logic       red, green, blue;

   vga_framebuffer_if hif ();

   vga_framebuffer #(
      .FB_W(160), .FB_H(120), .SCALE_SHIFT(2), .ADDR_W(15)
   ) dut (
      .clk(clk), .rst(rst), .cur_X(cur_X), .cur_Y(cur_Y), .vga_vs(vga_vs),
      .red(red), .green(green), .blue(blue), .host(hif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model: both buffers as pixel arrays ----------------
   logic [2:0] mem   [2][120][160];
   bit         known [2][120][160];
   bit         model_ok = 0;
   int         m_mode;          // 0 idle, 1 clearing, 2 waiting for vsync
   int         m_front, m_pos, p_x, p_y;
   logic [2:0] m_col;
   logic       m_vs_prev;
   bit         fall;
   logic [2:0] e_rgb;
   bit         e_known, e_clr_done, e_swap_done;

   always @(posedge clk) begin
      if (rst) begin
         model_ok = 1; m_mode = 0; m_front = 0; m_pos = 0; p_x = 0; p_y = 0;
         m_vs_prev = 1'b1; e_rgb = 3'b000; e_known = 1; e_clr_done = 0; e_swap_done = 0;
      end else if (model_ok) begin
         // pixel whose coordinate was registered one edge ago, from the buffer on show now
         e_rgb   = mem[m_front][p_y][p_x];
         e_known = known[m_front][p_y][p_x];
         p_x = int'(cur_X) / 4;
         p_y = int'(cur_Y) / 4;
         fall = m_vs_prev && !vga_vs;
         m_vs_prev = vga_vs;
         e_clr_done = 0;
         e_swap_done = 0;
         case (m_mode)
            0: begin
               if (hif.wr_valid && hif.wr_x < 160 && hif.wr_y < 120) begin
                  mem[1-m_front][hif.wr_y][hif.wr_x]   = hif.wr_rgb;
                  known[1-m_front][hif.wr_y][hif.wr_x] = 1;
               end
               if (hif.clr_req) begin
                  m_mode = 1; m_col = hif.clr_rgb; m_pos = 0;
               end else if (hif.swap_req) begin
                  m_mode = 2;
               end
            end
            1: begin
               mem[1-m_front][m_pos/160][m_pos%160]   = m_col;
               known[1-m_front][m_pos/160][m_pos%160] = 1;
               m_pos++;
               if (m_pos == 19200) begin
                  m_mode = 0; e_clr_done = 1;
               end
            end
            default: begin
               if (fall) begin
                  m_front = 1 - m_front; e_swap_done = 1; m_mode = 0;
               end
            end
         endcase
      end
   end

   // ---------------- per-cycle compare against the model ----------------
   always @(negedge clk) begin
      if (model_ok) begin
         check("busy", hif.busy, m_mode != 0);
         check("wr_ready", hif.wr_ready, (m_mode == 0) && !rst);
         check("clr_done", hif.clr_done, e_clr_done);
         check("swap_done", hif.swap_done, e_swap_done);
         check("front_sel", hif.front_sel, m_front[0]);
         if (e_known) check("rgb", {red, green, blue}, e_rgb);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_px(input int x, input int y, input logic [2:0] c);
      hif.wr_valid = 1'b1;
      hif.wr_x = x[7:0];
      hif.wr_y = y[6:0];
      hif.wr_rgb = c;
      tick();
      hif.wr_valid = 1'b0;
   endtask

   task automatic read_px(input int dx, input int dy, output logic [2:0] c);
      cur_X = dx[9:0];
      cur_Y = dy[9:0];
      tick();
      tick();
      c = {red, green, blue};
   endtask

   // swap request followed by one vsync falling edge; returns swap_done seen after that edge
   task automatic do_swap(output logic sd);
      hif.swap_req = 1'b1;
      tick();
      hif.swap_req = 1'b0;
      tick();
      vga_vs = 1'b0;
      tick();
      sd = hif.swap_done;
      vga_vs = 1'b1;
      tick();
   endtask

   // called just after the request edge; counts busy cycles and clr_done pulses
   task automatic wait_clear(output int busy_cycles, output int done_pulses);
      busy_cycles = 0;
      done_pulses = 0;
      for (int i = 0; i < 20000; i++) begin
         if (!hif.busy) break;
         busy_cycles++;
         if (hif.clr_done) done_pulses++;
         tick();
      end
      if (hif.clr_done) done_pulses++;
      tick();
      if (hif.clr_done) done_pulses++;
   endtask

   logic [2:0] px;
   logic       sd;
   int         nb, nd, ns;

   initial begin
      rst = 1'b1; cur_X = '0; cur_Y = '0; vga_vs = 1'b1;
      hif.wr_valid = 1'b0; hif.wr_x = '0; hif.wr_y = '0; hif.wr_rgb = '0;
      hif.clr_req = 1'b0; hif.clr_rgb = '0; hif.swap_req = 1'b0;

      // reset state
      tick(); tick(); tick();
      check("rst_rgb", {red, green, blue}, 3'b000);
      check("rst_wr_ready", hif.wr_ready, 1'b0);
      check("rst_busy", hif.busy, 1'b0);
      check("rst_front", hif.front_sel, 1'b0);
      rst = 1'b0;
      #1;
      check("rel_wr_ready", hif.wr_ready, 1'b1);

      // write (5,3)=101, swap, read its 4x4 block
      write_px(5, 3, 3'b101);
      do_swap(sd);
      check("t1_swap_done", sd, 1'b1);
      check("t1_front", hif.front_sel, 1'b1);
      for (int y = 12; y <= 15; y++)
         for (int x = 20; x <= 23; x++) begin
            read_px(x, y, px);
            check("t1_block", px, 3'b101);
         end

      // out-of-range writes are accepted and dropped
      write_px(0, 0, 3'b011);
      write_px(159, 119, 3'b110);
      write_px(0, 1, 3'b001);
      check("t2_ready_a", hif.wr_ready, 1'b1);
      write_px(160, 0, 3'b111);
      check("t2_ready_b", hif.wr_ready, 1'b1);
      write_px(0, 120, 3'b111);
      check("t2_ready_c", hif.wr_ready, 1'b1);
      do_swap(sd);
      check("t2_front", hif.front_sel, 1'b0);
      read_px(0, 0, px);     check("t2_px00", px, 3'b011);
      read_px(636, 476, px); check("t2_px_last", px, 3'b110);
      read_px(0, 4, px);     check("t2_px01", px, 3'b001);

      // full clear of the back buffer
      hif.clr_req = 1'b1; hif.clr_rgb = 3'b010;
      tick();
      hif.clr_req = 1'b0;
      wait_clear(nb, nd);
      check("t3_busy_cycles", nb, 19200);
      check("t3_done_pulses", nd, 1);
      do_swap(sd);
      check("t3_front", hif.front_sel, 1'b1);
      read_px(0, 0, px);     check("t3_px_first", px, 3'b010);
      read_px(639, 479, px); check("t3_px_last", px, 3'b010);

      // write + clear + swap in one cycle: write done, clear wins, swap dropped
      hif.wr_valid = 1'b1; hif.wr_x = 8'd1; hif.wr_y = 7'd1; hif.wr_rgb = 3'b111;
      hif.clr_req = 1'b1; hif.clr_rgb = 3'b100; hif.swap_req = 1'b1;
      tick();
      hif.wr_valid = 1'b0; hif.clr_req = 1'b0; hif.swap_req = 1'b0;
      wait_clear(nb, nd);
      check("t4_busy_cycles", nb, 19200);
      ns = 0;
      for (int k = 0; k < 2; k++) begin
         vga_vs = 1'b0; tick(); if (hif.swap_done) ns++;
         vga_vs = 1'b1; tick(); if (hif.swap_done) ns++;
      end
      check("t4_no_swap", ns, 0);
      check("t4_front_held", hif.front_sel, 1'b1);
      do_swap(sd);
      check("t4_front", hif.front_sel, 1'b0);
      read_px(4, 4, px); check("t4_px11", px, 3'b100);

      // swap waits for the vsync falling edge; a second request is ignored
      hif.swap_req = 1'b1;
      tick();
      hif.swap_req = 1'b0;
      ns = 0;
      for (int k = 0; k < 6; k++) begin
         if (k == 3) hif.swap_req = 1'b1;
         tick();
         hif.swap_req = 1'b0;
         if (hif.swap_done) ns++;
      end
      check("t5_front_hold", hif.front_sel, 1'b0);
      check("t5_busy_wait", hif.busy, 1'b1);
      vga_vs = 1'b0;
      tick();
      check("t5_swap_done", hif.swap_done, 1'b1);
      check("t5_front", hif.front_sel, 1'b1);
      if (hif.swap_done) ns++;
      vga_vs = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k == 2) vga_vs = 1'b0;
         if (k == 3) vga_vs = 1'b1;
         tick();
         if (hif.swap_done) ns++;
      end
      check("t5_one_pulse", ns, 1);
      check("t5_front_after", hif.front_sel, 1'b1);

      // reset in the middle of a clear
      hif.clr_req = 1'b1; hif.clr_rgb = 3'b011;
      tick();
      hif.clr_req = 1'b0;
      for (int k = 0; k < 5000; k++) tick();
      check("t6_busy_before", hif.busy, 1'b1);
      rst = 1'b1;
      tick();
      check("t6_busy", hif.busy, 1'b0);
      check("t6_clr_done", hif.clr_done, 1'b0);
      check("t6_front", hif.front_sel, 1'b0);
      check("t6_rgb", {red, green, blue}, 3'b000);
      check("t6_wr_ready_rst", hif.wr_ready, 1'b0);
      rst = 1'b0;
      #1;
      check("t6_wr_ready", hif.wr_ready, 1'b1);
      nd = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (hif.clr_done) nd++;
      end
      check("t6_no_done", nd, 0);
      read_px(0, 0, px);     check("t6_px_cleared", px, 3'b011);
      read_px(320, 248, px); check("t6_px_untouched", px, 3'b100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
